output_limiter: RTL



---
 rtl/limiter_pkg.sv | 37 +++
 rtl/sat_narrow_reg.sv | 38 +++
 rtl/output_limiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/limiter_pkg.sv
// Shared types and helpers for the output limiter and other width-reducing stages.
package limiter_pkg;

    typedef enum logic {
        UNITY   = 1'b0,
        REDUCED = 1'b1
    } lim_state_t;

    // Widest intermediate handled by sat_narrow; callers sign-extend into it.
    localparam int unsigned SAT_W = 64;

    function automatic int unsigned unity_gain(input int unsigned frac);
        return 32'(1) << frac;
    endfunction

    function automatic int unsigned prod_width(input int unsigned fxp);
        return 3 * fxp + 1;
    endfunction

    // Clamp x to the range of a w-bit signed value.
    function automatic logic signed [SAT_W-1:0] sat_narrow(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] v_max;
        logic signed [SAT_W-1:0] v_min;
        v_max = (64'sd1 <<< (w - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (w - 1));
        if (x > v_max) begin
            return v_max;
        end else if (x < v_min) begin
            return v_min;
        end
        return x;
    endfunction

endpackage

// File: rtl/sat_narrow_reg.sv
// Arithmetic right shift, saturate to OUT_W signed, and register with valid.
module sat_narrow_reg
    import limiter_pkg::*;
#(
    parameter int unsigned IN_W  = 49,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic signed [IN_W-1:0]  i_data,
    output logic                    o_valid,
    output logic signed [OUT_W-1:0] o_data,
    output logic signed [OUT_W-1:0] o_data_c
);

    logic signed [IN_W-1:0]  w_shifted;
    logic signed [SAT_W-1:0] w_ext;

    assign w_shifted = i_data >>> SHIFT;
    assign w_ext     = {{(SAT_W - IN_W){w_shifted[IN_W-1]}}, w_shifted};
    assign o_data_c  = OUT_W'(sat_narrow(w_ext, OUT_W));

    // o_data holds its last value between valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data <= o_data_c;
            end
        end
    end

endmodule

// File: rtl/output_limiter.sv
// Automatic-gain output limiter: narrows the 2x-wide effects stream to fxp_size
// with saturation, fast attack on over-threshold samples and timed release.
module output_limiter
    import limiter_pkg::*;
#(
    parameter int unsigned fxp_size           = 16,
    parameter int unsigned bits_per_gain_frac = 4,
    parameter int unsigned attack_shift       = 3,
    parameter int unsigned release_cnt_size   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic signed [2*fxp_size-1:0]  i_sample,
    input  logic [fxp_size-2:0]           i_threshold,
    input  logic [release_cnt_size-1:0]   i_release_period,
    output logic                          o_valid,
    output logic signed [fxp_size-1:0]    o_sample,
    output logic [fxp_size-1:0]           o_gain,
    output logic                          o_limiting
);

    localparam int unsigned IN_W   = 2 * fxp_size;
    localparam int unsigned PROD_W = prod_width(fxp_size);
    localparam int unsigned CNT_W  = release_cnt_size;
    localparam logic [fxp_size-1:0] GAIN_U   = fxp_size'(unity_gain(bits_per_gain_frac));
    localparam logic [fxp_size-1:0] GAIN_ONE = fxp_size'(1);

    lim_state_t                 r_state;
    lim_state_t                 w_state_nxt;
    logic [fxp_size-1:0]        r_gain;
    logic [fxp_size-1:0]        w_gain_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic signed [PROD_W-1:0]   r_prod;
    logic                       r_s1_valid;

    logic signed [PROD_W-1:0]   w_sample_ext;
    logic signed [PROD_W-1:0]   w_gain_ext;
    logic signed [PROD_W-1:0]   w_prod;
    logic signed [fxp_size-1:0] w_y;
    logic [fxp_size-1:0]        w_y_u;
    logic [fxp_size-1:0]        w_mag;
    logic                       w_over;
    logic [fxp_size-1:0]        w_step;
    logic [fxp_size-1:0]        w_step_eff;
    logic [fxp_size-1:0]        w_gain_dec;
    logic [fxp_size-1:0]        w_gain_inc;
    logic [CNT_W:0]             w_cnt_inc;
    logic [CNT_W-1:0]           w_period_eff;
    logic                       w_expire;

    // Stage 1: signed sample times zero-extended (non-negative) gain.
    assign w_sample_ext = {{(PROD_W - IN_W){i_sample[IN_W-1]}}, i_sample};
    assign w_gain_ext   = {{(PROD_W - fxp_size){1'b0}}, r_gain};
    assign w_prod       = w_sample_ext * w_gain_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_prod     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_prod <= w_prod;
            end
        end
    end

    // Stage 2: shift, saturate, register the output sample.
    sat_narrow_reg #(
        .IN_W  (PROD_W),
        .OUT_W (fxp_size),
        .SHIFT (bits_per_gain_frac)
    ) u_narrow (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_s1_valid),
        .i_data   (r_prod),
        .o_valid  (o_valid),
        .o_data   (o_sample),
        .o_data_c (w_y)
    );

    // Unsigned magnitude so the most negative value maps to 2^(fxp_size-1).
    assign w_y_u  = w_y;
    assign w_mag  = w_y[fxp_size-1] ? (~w_y_u + GAIN_ONE) : w_y_u;
    assign w_over = w_mag > {1'b0, i_threshold};

    assign w_step       = r_gain >> attack_shift;
    assign w_step_eff   = (w_step == '0) ? GAIN_ONE : w_step;
    assign w_gain_dec   = (r_gain > w_step_eff) ? (r_gain - w_step_eff) : GAIN_ONE;
    assign w_gain_inc   = r_gain + GAIN_ONE;
    assign w_cnt_inc    = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    assign w_period_eff = (i_release_period == '0) ? CNT_W'(1) : i_release_period;
    assign w_expire     = w_cnt_inc >= {1'b0, w_period_eff};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= UNITY;
            r_gain  <= GAIN_U;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gain  <= w_gain_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Gain FSM: over-threshold wins over a simultaneous release expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_cnt_nxt   = r_cnt;
        if (r_s1_valid) begin
            if (w_over) begin
                w_gain_nxt  = w_gain_dec;
                w_cnt_nxt   = '0;
                w_state_nxt = REDUCED;
            end else if (r_state == REDUCED) begin
                w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
                if (w_expire) begin
                    w_gain_nxt = w_gain_inc;
                    w_cnt_nxt  = '0;
                    if (w_gain_inc == GAIN_U) begin
                        w_state_nxt = UNITY;
                    end
                end
            end else begin
                w_cnt_nxt  = '0;
                w_gain_nxt = GAIN_U;
            end
        end
    end

    assign o_gain     = r_gain;
    assign o_limiting = (r_state == REDUCED);

endmodule
